crc32_frame_ctrl: RTL and testbench

Frame sequencer that owns the byte-parallel CRC-32 engine (`CRC_32_paraller`). It accepts a byte stream with valid/ready/last framing and drives the engine's `load`, `crc_in` and `d_finish` in the required order. It forwards each frame's payload downstream and appends the 4 CRC bytes read back from `crc_out`. It sits between the packet source and the line-side transmitter, and aborts malformed frames.

---
 rtl/crc32_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_crc32_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for a byte-parallel CRC-32 engine: forwards payload, then appends the 4 engine CRC bytes.
// Registered outputs; payload 1 cycle after accept, CRC tail 3 cycles after last byte; no downstream backpressure.
module crc32_frame_ctrl #(
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s_valid,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_last,
  output logic             o_s_ready,
  output logic             o_crc_load,
  output logic [7:0]       o_crc_data,
  output logic             o_crc_finish,
  input  logic [7:0]       i_crc_result,
  output logic             o_m_valid,
  output logic [7:0]       o_m_data,
  output logic             o_m_last,
  output logic             o_m_abort,
  output logic             o_err_gap,
  output logic             o_err_len,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DATA, S_FIN, S_CRCF, S_CRCW, S_TAIL, S_ERR, S_ABORT
  } state_t;

  state_t            r_state, w_state;
  logic [15:0]       r_len, w_len;
  logic [1:0]        r_tail, w_tail;
  logic              w_acc, w_err_gap, w_err_len, w_tail_end;

  logic              r_s_ready, r_crc_load, r_crc_finish, r_m_valid, r_m_last;
  logic              r_m_abort, r_err_gap, r_err_len, r_busy;
  logic [7:0]        r_crc_data, r_m_data;
  logic [CNT_W-1:0]  r_frame_cnt;

  always_comb begin
    w_state   = r_state;
    w_len     = r_len;
    w_tail    = r_tail;
    w_acc     = 1'b0;
    w_err_gap = 1'b0;
    w_err_len = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_s_valid) w_state = S_LOAD;
      S_LOAD, S_DATA: begin
        // The engine folds every cycle, so a missing byte mid-frame is unrecoverable.
        if (i_s_valid) begin
          w_acc = 1'b1;
          w_len = (r_state == S_LOAD) ? 16'd1 : r_len + 16'd1;
          if (i_s_last) begin
            w_state = S_FIN;
          end else if (w_len == 16'(MAX_LEN)) begin
            w_state   = S_ERR;
            w_err_len = 1'b1;
          end else begin
            w_state = S_DATA;
          end
        end else begin
          w_state   = S_ERR;
          w_err_gap = 1'b1;
        end
      end
      S_FIN:  w_state = S_CRCF;
      S_CRCF: w_state = S_CRCW;
      S_CRCW: begin
        w_state = S_TAIL;
        w_tail  = 2'd0;
      end
      S_TAIL: begin
        if (r_tail == 2'd3) w_state = S_IDLE;
        else                w_tail  = r_tail + 2'd1;
      end
      S_ERR:   w_state = S_ABORT;
      S_ABORT: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_tail_end = (w_state == S_TAIL) && (w_tail == 2'd3);
  end

  // Outputs are registered from the next state so each output lines up with the state it belongs to.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_tail       <= '0;
      r_s_ready    <= 1'b0;
      r_crc_load   <= 1'b0;
      r_crc_finish <= 1'b0;
      r_crc_data   <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_m_abort    <= 1'b0;
      r_err_gap    <= 1'b0;
      r_err_len    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state;
      r_len        <= w_len;
      r_tail       <= w_tail;
      r_s_ready    <= (w_state == S_LOAD) || (w_state == S_DATA);
      r_crc_load   <= (w_state == S_LOAD);
      r_crc_finish <= (w_state == S_CRCF);
      r_crc_data   <= w_acc ? i_s_data : 8'h00;
      r_m_valid    <= w_acc || (w_state == S_TAIL);
      r_m_data     <= w_acc ? i_s_data : ((w_state == S_TAIL) ? i_crc_result : 8'h00);
      r_m_last     <= w_tail_end;
      r_m_abort    <= (w_state == S_ABORT);
      r_err_gap    <= w_err_gap;
      r_err_len    <= w_err_len;
      r_busy       <= (w_state != S_IDLE);
      if (w_tail_end) r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_s_ready    = r_s_ready;
  assign o_crc_load   = r_crc_load;
  assign o_crc_data   = r_crc_data;
  assign o_crc_finish = r_crc_finish;
  assign o_m_valid    = r_m_valid;
  assign o_m_data     = r_m_data;
  assign o_m_last     = r_m_last;
  assign o_m_abort    = r_m_abort;
  assign o_err_gap    = r_err_gap;
  assign o_err_len    = r_err_len;
  assign o_busy       = r_busy;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Bench for crc32_frame_ctrl: a CRC-32 engine model drives crc_result; every cycle of every frame is checked.
module tb_crc32_frame_ctrl;

  localparam int MAXL = 9;
  localparam int CW   = 2;
  typedef logic [26:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready, crc_load, crc_finish, m_valid, m_last, m_abort;
  logic          err_gap, err_len, busy;
  logic [7:0]    crc_data, m_data, crc_result;
  logic [CW-1:0] frame_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_cnt = 0;
  bit          stub = 1'b1;
  logic [7:0]  pl[$];
  logic [31:0] eng_crc, eng_sh;

  always #5 clk = ~clk;

  crc32_frame_ctrl #(.MAX_LEN(MAXL), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_valid(s_valid), .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(s_ready),
    .o_crc_load(crc_load), .o_crc_data(crc_data), .o_crc_finish(crc_finish),
    .i_crc_result(crc_result),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_last(m_last), .o_m_abort(m_abort),
    .o_err_gap(err_gap), .o_err_len(err_len), .o_busy(busy), .o_frame_cnt(frame_cnt)
  );

  // Engine model: non-reflected shift register fed LSB-first, reflected and inverted on finish.
  function automatic logic [31:0] eng_fold(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] eng_final(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_crc <= 32'h0;
      eng_sh  <= 32'h0;
    end else if (crc_load) begin
      eng_crc <= 32'hFFFFFFFF;
    end else if (crc_finish) begin
      eng_sh <= stub ? 32'hDEADBEEF : eng_final(eng_crc);
    end else begin
      eng_crc <= eng_fold(eng_crc, crc_data);
      eng_sh  <= {eng_sh[23:0], 8'h00};
    end
  end
  assign crc_result = eng_sh[31:24];

  // Reference: textbook reflected CRC-32 over the whole payload.
  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      c = c ^ {24'h0, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic vec_t obs();
    return {s_ready, crc_load, crc_data, crc_finish, m_valid, m_data,
            m_last, m_abort, err_gap, err_len, busy, frame_cnt};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic ld, input logic [7:0] cd,
                              input logic fin, input logic mv, input logic [7:0] md,
                              input logic ml, input logic ma, input logic eg, input logic el,
                              input logic bz, input int cnt);
    logic [CW-1:0] c;
    c = CW'(cnt % (1 << CW));
    return {rdy, ld, cd, fin, mv, md, ml, ma, eg, el, bz, c};
  endfunction

  task automatic check(input string tag, input int k, input vec_t e);
    vec_t o;
    o = obs();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      @(negedge clk);
      check("idle", i, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic fill_rand(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // kind 0: good frame of n bytes; 1: valid drops after g bytes; 2: MAXL+1 bytes, no last.
  task automatic run_frame(input string tag, input int kind, input int n, input int g,
                           input logic [31:0] exp_crc, input int stop_k);
    int acc, rdy_end, busy_end, idx, sh;
    logic vld, pay, tl;
    logic [7:0] pd, td;
    logic [31:0] tmp;
    acc      = (kind == 0) ? n : (kind == 1) ? g : MAXL;
    rdy_end  = (kind == 0) ? n : (kind == 1) ? g + 1 : MAXL;
    busy_end = (kind == 0) ? n + 7 : (kind == 1) ? g + 3 : MAXL + 2;
    for (int k = 0; k <= busy_end; k++) begin
      @(posedge clk); #1;
      vld = (kind == 0) ? (k <= n) : (kind == 1) ? (k <= g) : (k <= MAXL + 1);
      idx = (k == 0) ? 0 : k - 1;
      s_valid = vld;
      s_data  = 8'h00;
      if (vld) s_data = pl[idx];
      s_last  = vld && (kind == 0) && (idx == n - 1);
      @(negedge clk);
      pay = (k >= 2) && (k <= acc + 1);
      pd  = 8'h00;
      if (pay) pd = pl[k-2];
      tl  = (kind == 0) && (k >= n + 4) && (k <= n + 7);
      td  = 8'h00;
      if (tl) begin
        sh  = k - n - 4;
        tmp = exp_crc >> (8 * (3 - sh));
        td  = tmp[7:0];
      end
      if (kind == 0 && k == n + 7) exp_cnt++;
      check(tag, k, mk((k >= 1) && (k <= rdy_end), k == 1, pd,
                       (kind == 0) && (k == n + 2), pay || tl, pay ? pd : td,
                       (kind == 0) && (k == n + 7),
                       ((kind == 1) && (k == g + 3)) || ((kind == 2) && (k == MAXL + 2)),
                       (kind == 1) && (k == g + 2), (kind == 2) && (k == MAXL + 1),
                       k >= 1, exp_cnt));
      if (k == stop_k) break;
    end
  endtask

  task automatic good_rand(input string tag, input int n);
    fill_rand(n);
    run_frame(tag, 0, n, 0, crc32_ref(), -1);
  endtask

  initial begin
    int r, n;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset", i, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1 rst = 1'b1;
    idle(2);

    pl = {8'h11, 8'h22, 8'h33};
    run_frame("stub3", 0, 3, 0, 32'hDEADBEEF, -1);
    stub = 1'b0;
    idle(1);

    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame("check9", 0, 9, 0, 32'hCBF43926, -1);

    good_rand("one_byte", 1);
    good_rand("back2back", $urandom_range(1, MAXL));

    fill_rand(5);
    run_frame("gap2of5", 1, 5, 2, 32'h0, -1);
    good_rand("after_gap", 5);
    fill_rand(3);
    run_frame("gap_load", 1, 3, 0, 32'h0, -1);
    idle(1);

    fill_rand(MAXL + 1);
    run_frame("len_over", 2, 0, 0, 32'h0, -1);
    good_rand("after_len", MAXL);

    for (int f = 0; f < 16; f++) begin
      r = $urandom_range(0, 5);
      n = $urandom_range(2, MAXL);
      if (r <= 3) begin
        good_rand("rand_good", $urandom_range(1, MAXL));
      end else if (r == 4) begin
        fill_rand(n);
        run_frame("rand_gap", 1, n, $urandom_range(0, n - 1), 32'h0, -1);
      end else begin
        fill_rand(MAXL + 1);
        run_frame("rand_len", 2, 0, 0, 32'h0, -1);
      end
      idle($urandom_range(0, 2));
    end

    fill_rand(4);
    run_frame("rst_tail", 0, 4, 0, crc32_ref(), 4 + 5);
    #2 rst = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    exp_cnt = 0;
    #1 check("rst_async", 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_hold", 1, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b1;
    idle(1);

    for (int f = 0; f < 5; f++) good_rand("wrap", $urandom_range(1, MAXL));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
